aer_rx_receiver: RTL and testbench



---
 rtl/aer_rx_receiver.sv | 117 +++++++++++
 tb/tb_aer_rx_receiver.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_rx_receiver.sv
// AER 4-phase bundled-data receiver: synchronises REQ, captures the address, pushes one event per handshake into the spike FIFO.
// Optional accepted-event counter (EVT_CNT_o, CNT_CLR_i) is built when AER_RX_EVT_CNT_EN is defined.
module aer_rx_receiver #(
  parameter int M           = 8,
  parameter int SYNC_STAGES = 2
`ifdef AER_RX_EVT_CNT_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             RX_EN_i,
  input  logic             AER_REQ_i,
  input  logic [M-1:0]     AER_ADDR_i,
  output logic             AER_ACK_o,
  input  logic             FIFO_full_i,
  output logic             FIFO_w_en_o,
  output logic [M-1:0]     FIFO_w_data_o,
  output logic             BUSY_o,
  output logic [1:0]       STATE_o
`ifdef AER_RX_EVT_CNT_EN
  ,
  output logic [CNT_W-1:0] EVT_CNT_o,
  input  logic             CNT_CLR_i
`endif
);

  typedef enum logic [1:0] {
    S_RESYNC = 2'd0,
    S_IDLE   = 2'd1,
    S_PUSH   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  // Handshake: an event is taken when req_s is high in IDLE; ACK rises only
  // on the edge ending the write cycle and falls once req_s is seen low.
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_q, ack_d;
  logic [M-1:0]           addr_q, addr_d;
  logic                   req_s;
  logic                   w_en;

  // Stages reset high so a REQ held across reset is never mistaken for a new rising edge.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], AER_REQ_i};
  assign req_s  = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    addr_d  = addr_q;
    w_en    = 1'b0;
    case (state_q)
      S_RESYNC: if (!req_s) state_d = S_IDLE;
      S_IDLE: begin
        if (req_s && RX_EN_i) begin
          addr_d  = AER_ADDR_i;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (!FIFO_full_i) begin
          w_en    = 1'b1;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_RESYNC;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_RESYNC;
      sync_q  <= '1;
      ack_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
    end
  end

  assign AER_ACK_o     = ack_q;
  assign FIFO_w_en_o   = w_en;
  assign FIFO_w_data_o = addr_q;
  assign BUSY_o        = (state_q != S_IDLE);
  assign STATE_o       = state_q;

`ifdef AER_RX_EVT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a coincident write.
  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR_i)  cnt_d = '0;
    else if (w_en)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign EVT_CNT_o = cnt_q;
`endif

endmodule

// File: tb/tb_aer_rx_receiver.sv
// Bench for aer_rx_receiver: scenario tasks, randomized handshakes, scoreboard of expected FIFO writes.
module tb_aer_rx_receiver;
  localparam int M    = 8;
  localparam int SYNC = 2;
  localparam int CW   = 16;

  logic         CLK = 1'b0;
  logic         RSTN = 1'b0;
  logic         RX_EN_i = 1'b1;
  logic         AER_REQ_i = 1'b0;
  logic [M-1:0] AER_ADDR_i = '0;
  logic         AER_ACK_o;
  logic         FIFO_full_i = 1'b0;
  logic         FIFO_w_en_o;
  logic [M-1:0] FIFO_w_data_o;
  logic         BUSY_o;
  logic [1:0]   STATE_o;
`ifdef AER_RX_EVT_CNT_EN
  logic [CW-1:0] EVT_CNT_o;
  logic          CNT_CLR_i = 1'b0;
`endif

  aer_rx_receiver #(
    .M(M), .SYNC_STAGES(SYNC)
`ifdef AER_RX_EVT_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .RX_EN_i(RX_EN_i), .AER_REQ_i(AER_REQ_i),
    .AER_ADDR_i(AER_ADDR_i), .AER_ACK_o(AER_ACK_o), .FIFO_full_i(FIFO_full_i),
    .FIFO_w_en_o(FIFO_w_en_o), .FIFO_w_data_o(FIFO_w_data_o), .BUSY_o(BUSY_o),
    .STATE_o(STATE_o)
`ifdef AER_RX_EVT_CNT_EN
    , .EVT_CNT_o(EVT_CNT_o), .CNT_CLR_i(CNT_CLR_i)
`endif
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int write_cnt = 0;
  logic [M-1:0]  exp_q[$];
  logic [CW-1:0] model_cnt = '0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every write must match the oldest outstanding event, never while full
  logic ack_prev = 1'b0;
  logic wen_prev = 1'b0;
  always @(negedge CLK) begin
    if (!RSTN) begin
      ack_prev = 1'b0;
      wen_prev = 1'b0;
    end else begin
      if (FIFO_w_en_o) begin
        n_checks++;
        if (FIFO_full_i) begin
          n_errors++;
          $display("FAIL write_into_full: w_en=1 full=1 data=%02h, required no write", FIFO_w_data_o);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_write: data=%02h, required no write", FIFO_w_data_o);
        end else begin
          logic [M-1:0] e;
          e = exp_q.pop_front();
          if (FIFO_w_data_o !== e) begin
            n_errors++;
            $display("FAIL write_data: got %02h required %02h", FIFO_w_data_o, e);
          end
        end
        write_cnt++;
      end
      if (AER_ACK_o && !ack_prev) begin
        n_checks++;
        if (!wen_prev) begin
          n_errors++;
          $display("FAIL ack_before_write: ack rose with w_en=%0b in previous cycle, required 1", wen_prev);
        end
      end
      if (!AER_ACK_o && ack_prev) begin
        n_checks++;
        if (AER_REQ_i) begin
          n_errors++;
          $display("FAIL ack_dropped_early: ack fell with req=1, required req=0");
        end
      end
      ack_prev = AER_ACK_o;
      wen_prev = FIFO_w_en_o;
    end
  end

  // driver tasks
  task automatic wait_ack(input logic lvl, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (AER_ACK_o === lvl) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic handshake(input logic [M-1:0] addr, input int full_pct, output logic ok);
    int c;
    logic got;
    exp_q.push_back(addr);
    model_cnt++;
    @(posedge CLK); #1;
    AER_ADDR_i = addr;
    AER_REQ_i  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge CLK);
      if (AER_ACK_o === 1'b1) got = 1'b1;
      else begin
        @(posedge CLK); #1;
        if (full_pct > 0) FIFO_full_i = ($urandom_range(0, 99) < full_pct);
      end
    end
    FIFO_full_i = 1'b0;
    repeat ($urandom_range(0, 3)) @(posedge CLK);
    @(posedge CLK); #1;
    AER_REQ_i  = 1'b0;
    AER_ADDR_i = M'($urandom);
    wait_ack(1'b0, c);
    ok = got && (c > 0);
  endtask

  // scenarios
  task automatic test_reset;
    RSTN = 1'b0; AER_REQ_i = 1'b0; FIFO_full_i = 1'b0; RX_EN_i = 1'b1;
    model_cnt = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (AER_ACK_o !== 1'b0 || FIFO_w_en_o !== 1'b0 || FIFO_w_data_o !== 8'h00 || BUSY_o !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_values: ack=%0b wen=%0b data=%02h busy=%0b, required 0 0 00 1",
               AER_ACK_o, FIFO_w_en_o, FIFO_w_data_o, BUSY_o);
    end
`ifdef AER_RX_EVT_CNT_EN
    n_checks++;
    if (EVT_CNT_o !== '0) begin
      n_errors++;
      $display("FAIL reset_cnt: got %0d required 0", EVT_CNT_o);
    end
`endif
    RSTN = 1'b1;
    repeat (SYNC) begin @(posedge CLK); @(negedge CLK); end
    n_checks++;
    if (BUSY_o !== 1'b1) begin
      n_errors++;
      $display("FAIL resync_hold: busy=%0b after %0d edges, required 1", BUSY_o, SYNC);
    end
    @(posedge CLK); @(negedge CLK);
    n_checks++;
    if (BUSY_o !== 1'b0) begin
      n_errors++;
      $display("FAIL resync_exit: busy=%0b, required 0", BUSY_o);
    end
  endtask

  task automatic test_basic;
    int lat, c;
    exp_q.push_back(8'h5A);
    model_cnt++;
    @(posedge CLK); #1;
    AER_ADDR_i = 8'h5A;
    AER_REQ_i  = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); @(negedge CLK);
      if (FIFO_w_en_o === 1'b1) begin lat = i; break; end
    end
    n_checks++;
    if (lat != SYNC + 1) begin
      n_errors++;
      $display("FAIL basic_wen_latency: got %0d required %0d", lat, SYNC + 1);
    end
    n_checks++;
    if (FIFO_w_data_o !== 8'h5A || AER_ACK_o !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_write_cycle: data=%02h ack=%0b, required 5a 0", FIFO_w_data_o, AER_ACK_o);
    end
    @(posedge CLK); @(negedge CLK);
    n_checks++;
    if (AER_ACK_o !== 1'b1 || FIFO_w_en_o !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_ack_next: ack=%0b wen=%0b, required 1 0", AER_ACK_o, FIFO_w_en_o);
    end
    AER_REQ_i = 1'b0;
    wait_ack(1'b0, c);
    n_checks++;
    if (c != SYNC + 1) begin
      n_errors++;
      $display("FAIL basic_ack_fall_latency: got %0d required %0d", c, SYNC + 1);
    end
    n_checks++;
    if (BUSY_o !== 1'b0 || FIFO_w_data_o !== 8'h5A) begin
      n_errors++;
      $display("FAIL basic_idle: busy=%0b data=%02h, required 0 5a", BUSY_o, FIFO_w_data_o);
    end
  endtask

  task automatic test_fifo_full;
    int bad, c;
    exp_q.push_back(8'h11);
    model_cnt++;
    @(posedge CLK); #1;
    FIFO_full_i = 1'b1;
    AER_ADDR_i  = 8'h11;
    AER_REQ_i   = 1'b1;
    bad = 0;
    repeat (SYNC + 11) begin
      @(negedge CLK);
      if (FIFO_w_en_o !== 1'b0 || AER_ACK_o !== 1'b0) bad++;
      @(posedge CLK);
    end
    @(negedge CLK);
    n_checks++;
    if (bad != 0 || BUSY_o !== 1'b1) begin
      n_errors++;
      $display("FAIL full_stall: %0d cycles with wen/ack high, busy=%0b, required 0 cycles busy=1", bad, BUSY_o);
    end
    FIFO_full_i = 1'b0;
    #1;
    n_checks++;
    if (FIFO_w_en_o !== 1'b1 || FIFO_w_data_o !== 8'h11) begin
      n_errors++;
      $display("FAIL full_release_write: wen=%0b data=%02h, required 1 11", FIFO_w_en_o, FIFO_w_data_o);
    end
    @(posedge CLK); @(negedge CLK);
    n_checks++;
    if (AER_ACK_o !== 1'b1 || FIFO_w_en_o !== 1'b0) begin
      n_errors++;
      $display("FAIL full_ack: ack=%0b wen=%0b, required 1 0", AER_ACK_o, FIFO_w_en_o);
    end
    AER_REQ_i = 1'b0;
    wait_ack(1'b0, c);
    n_checks++;
    if (c < 0) begin
      n_errors++;
      $display("FAIL full_ack_release: ack stuck high, required low");
    end
  endtask

  task automatic test_back_to_back;
    int w0, fails;
    logic ok;
    w0 = write_cnt;
    fails = 0;
    for (int i = 0; i < 256; i++) begin
      handshake(M'(i), 0, ok);
      if (!ok) fails++;
    end
    @(negedge CLK);
    n_checks++;
    if (fails != 0) begin
      n_errors++;
      $display("FAIL b2b_handshakes: %0d incomplete, required 0", fails);
    end
    n_checks++;
    if (write_cnt - w0 != 256 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_writes: got %0d writes, %0d pending, required 256 and 0", write_cnt - w0, exp_q.size());
    end
`ifdef AER_RX_EVT_CNT_EN
    n_checks++;
    if (EVT_CNT_o !== model_cnt) begin
      n_errors++;
      $display("FAIL b2b_evt_cnt: got %0d required %0d", EVT_CNT_o, model_cnt);
    end
`endif
  endtask

  task automatic test_rx_en;
    int w0, c;
    w0 = write_cnt;
    RX_EN_i = 1'b0;
    @(posedge CLK); #1;
    AER_ADDR_i = 8'h44;
    AER_REQ_i  = 1'b1;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (BUSY_o !== 1'b0 || AER_ACK_o !== 1'b0 || write_cnt != w0) begin
      n_errors++;
      $display("FAIL rx_disabled: busy=%0b ack=%0b writes=%0d, required 0 0 0", BUSY_o, AER_ACK_o, write_cnt - w0);
    end
    exp_q.push_back(8'h44);
    model_cnt++;
    RX_EN_i = 1'b1;
    wait_ack(1'b1, c);
    n_checks++;
    if (c < 0 || write_cnt - w0 != 1) begin
      n_errors++;
      $display("FAIL rx_enable_capture: ack_wait=%0d writes=%0d, required >0 and 1", c, write_cnt - w0);
    end
    RX_EN_i   = 1'b0;
    AER_REQ_i = 1'b0;
    wait_ack(1'b0, c);
    @(negedge CLK);
    n_checks++;
    if (c < 0 || BUSY_o !== 1'b0 || write_cnt - w0 != 1) begin
      n_errors++;
      $display("FAIL rx_disable_in_ack: ack_wait=%0d busy=%0b writes=%0d, required >0 0 1", c, BUSY_o, write_cnt - w0);
    end
    RX_EN_i = 1'b1;
  endtask

  task automatic test_reset_mid;
    int w0, c, bad;
    logic ok;
    exp_q.push_back(8'h22);
    model_cnt++;
    @(posedge CLK); #1;
    AER_ADDR_i = 8'h22;
    AER_REQ_i  = 1'b1;
    wait_ack(1'b1, c);
    #2;
    RSTN = 1'b0;
    #1;
    n_checks++;
    if (c < 0 || AER_ACK_o !== 1'b0 || FIFO_w_en_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_ack: ack_wait=%0d ack=%0b wen=%0b, required >0 0 0", c, AER_ACK_o, FIFO_w_en_o);
    end
    model_cnt = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    w0 = write_cnt;
    bad = 0;
    repeat (10) begin
      @(posedge CLK); @(negedge CLK);
      if (AER_ACK_o !== 1'b0 || BUSY_o !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0 || write_cnt != w0) begin
      n_errors++;
      $display("FAIL reset_mid_hold: %0d bad cycles, %0d writes, required 0 and 0", bad, write_cnt - w0);
    end
    @(posedge CLK); #1;
    AER_REQ_i = 1'b0;
    repeat (SYNC + 2) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (BUSY_o !== 1'b0 || write_cnt != w0) begin
      n_errors++;
      $display("FAIL reset_mid_resync: busy=%0b writes=%0d, required 0 0", BUSY_o, write_cnt - w0);
    end
    handshake(8'h33, 0, ok);
    @(negedge CLK);
    n_checks++;
    if (!ok || write_cnt - w0 != 1) begin
      n_errors++;
      $display("FAIL reset_mid_new_event: ok=%0b writes=%0d, required 1 1", ok, write_cnt - w0);
    end
  endtask

  task automatic test_random_full;
    int fails;
    logic ok;
    fails = 0;
    for (int i = 0; i < 40; i++) begin
      handshake(M'($urandom), 40, ok);
      if (!ok) fails++;
    end
    @(negedge CLK);
    n_checks++;
    if (fails != 0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL random_full: %0d incomplete, %0d pending, required 0 and 0", fails, exp_q.size());
    end
`ifdef AER_RX_EVT_CNT_EN
    n_checks++;
    if (EVT_CNT_o !== model_cnt) begin
      n_errors++;
      $display("FAIL random_full_cnt: got %0d required %0d", EVT_CNT_o, model_cnt);
    end
`endif
  endtask

`ifdef AER_RX_EVT_CNT_EN
  task automatic test_cnt_clr;
    int c;
    logic ok;
    exp_q.push_back(8'h77);
    @(posedge CLK); #1;
    AER_ADDR_i = 8'h77;
    AER_REQ_i  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (FIFO_w_en_o === 1'b1) break;
    end
    CNT_CLR_i = 1'b1;
    @(posedge CLK); #1;
    CNT_CLR_i = 1'b0;
    model_cnt = '0;
    @(negedge CLK);
    n_checks++;
    if (EVT_CNT_o !== '0) begin
      n_errors++;
      $display("FAIL cnt_clr_priority: got %0d required 0", EVT_CNT_o);
    end
    AER_REQ_i = 1'b0;
    wait_ack(1'b0, c);
    handshake(8'h78, 0, ok);
    @(negedge CLK);
    n_checks++;
    if (!ok || EVT_CNT_o !== model_cnt) begin
      n_errors++;
      $display("FAIL cnt_after_clr: ok=%0b cnt=%0d, required 1 and %0d", ok, EVT_CNT_o, model_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_fifo_full();
    test_back_to_back();
    test_rx_en();
    test_reset_mid();
    test_random_full();
`ifdef AER_RX_EVT_CNT_EN
    test_cnt_clr();
`endif
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL final_pending: %0d events never written, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
